layer_argmax: RTL and testbench
===============================

// Module: layer_argmax
// PURPOSE
//   Downstream classifier stage for the final neuron layer. Captures the layer's parallel
//   signed outputs with a valid/ready handshake, then scans them one neuron per cycle.
//   Returns the index and value of the maximum, giving the network's predicted class.
//   Sequential scan keeps to one comparator regardless of NEURON_NUM.
// PARAMETERS
//   LAYER_DATA_WIDTH  16  layer input data width; each neuron output is LAYER_DATA_WIDTH+8 bits signed
//   NEURON_NUM        10  number of neuron outputs (classes) to compare; >= 1
//   IDX_W             $clog2(NEURON_NUM)>1?$clog2(NEURON_NUM):1  width of class index (derived, do not override)
// PORTS
//   clk          in   1                    rising-edge clock
//   rst_n        in   1                    asynchronous active-low reset
//   in_valid     in   1                    data_in holds a complete layer result
//   in_ready     out  1                    block can accept a vector (IDLE only)
//   data_in      in   NEURON_NUM x (LAYER_DATA_WIDTH+8), signed   neuron outputs, [0:NEURON_NUM-1]
//   out_valid    out  1                    class_idx/class_score valid
//   out_ready    in   1                    consumer accepts result
//   class_idx    out  IDX_W                index of maximum neuron output
//   class_score  out  LAYER_DATA_WIDTH+8, signed   value of maximum neuron output
//   busy         out  1                    high in SCAN or DONE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; in_ready=0 during reset, 1 from first clock after release;
//     out_valid=0, class_idx=0, class_score=0, busy=0, scan counter=0, snapshot cleared.
//   FSM IDLE -> SCAN -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&&in_ready at edge T: snapshot all NEURON_NUM entries,
//     best_val<=data_in[0], best_idx<=0, idx<=1. Next state SCAN, or DONE if NEURON_NUM==1.
//   SCAN: one compare per cycle, signed: if snap[idx] > best_val (strictly greater), update best.
//     Ties keep the lower index. idx increments; after compare of index NEURON_NUM-1 -> DONE.
//     data_in/in_valid ignored in SCAN; snapshot decouples from upstream changes.
//   DONE: out_valid=1, class_idx=best_idx, class_score=best_val, held stable while !out_ready.
//     On out_valid&&out_ready -> IDLE; out_valid drops next cycle.
//     No same-cycle re-accept; in_ready rises the cycle after handoff.
//   Latency: accept at edge T -> out_valid high after edge T+NEURON_NUM-1, or T+1 if NEURON_NUM==1.
//   Throughput: one vector per NEURON_NUM+1 cycles with out_ready held high.
//   in_ready is a registered function of state only; no combinational path from in_valid or out_ready.
//   Width: comparisons at full LAYER_DATA_WIDTH+8 bits signed, no truncation or saturation.
//     Most-negative value is legal.
//   Reset mid-SCAN or mid-DONE: result discarded, outputs return to reset values immediately (async).
//   Counter wrap: idx never exceeds NEURON_NUM-1; cleared on every accept.
// TESTING
//   NEURON_NUM=10, data_in = 0,1,...,9 -> class_idx=9, class_score=9, out_valid 9 cycles after accept.
//   data_in all = -5 (tie) -> class_idx=0, class_score=-5; tie at [3]=[7]=100, others 0 -> class_idx=3.
//   All negative: {-100,-3,-50,...,-2^23} (W=24) -> class_idx=1, class_score=-3; min value never chosen.
//   Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
//     in_valid pulses are ignored and the next vector is accepted only after handoff.
//   data_in changes every cycle during SCAN -> result reflects the snapshot from the accept edge only.
//   rst_n low 2 cycles mid-SCAN (idx=4) -> out_valid=0, class_idx=0, class_score=0 immediately.
//     After release, a fresh vector 0..9 gives class_idx=9.
//   NEURON_NUM=1 build: accept {42} -> out_valid next cycle, class_idx=0, class_score=42.

Source files
------------

// File: rtl/layer_argmax.sv
// rtl/layer_argmax.sv - sequential argmax over the final neuron layer outputs
module layer_argmax #(
    parameter int LAYER_DATA_WIDTH = 16,
    parameter int NEURON_NUM       = 10,
    parameter int IDX_W            = ($clog2(NEURON_NUM) > 1) ? $clog2(NEURON_NUM) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [LAYER_DATA_WIDTH+7:0] data_in [0:NEURON_NUM-1],
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [IDX_W-1:0]                   class_idx,
    output logic signed [LAYER_DATA_WIDTH+7:0] class_score,
    output logic                               busy
);

    localparam int DW = LAYER_DATA_WIDTH + 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // First index compared in SCAN; a single-neuron layer never scans.
    localparam logic [IDX_W-1:0] FIRST_IDX = (NEURON_NUM > 1) ? IDX_W'(1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NEURON_NUM - 1);

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       best_idx;
    logic signed [DW-1:0]   best_val;
    logic signed [DW-1:0]   snap [0:NEURON_NUM-1];
    logic                   accept;

    assign accept      = (state == S_IDLE) && in_valid && in_ready;
    assign out_valid   = (state == S_DONE);
    assign busy        = (state != S_IDLE);
    assign class_idx   = best_idx;
    assign class_score = best_val;

    // Next-state selection for the IDLE -> SCAN -> DONE -> IDLE sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (NEURON_NUM == 1) ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                if (idx == LAST_IDX) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, registered in_ready and the snapshot/scan datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            idx      <= '0;
            best_idx <= '0;
            best_val <= '0;
            for (int i = 0; i < NEURON_NUM; i++) begin
                snap[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            // Depends only on the state being entered, so there is no
            // combinational path from in_valid or out_ready to in_ready.
            in_ready <= (state_nxt == S_IDLE);
            if (accept) begin
                snap     <= data_in;
                best_val <= data_in[0];
                best_idx <= '0;
                idx      <= FIRST_IDX;
            end else if (state == S_SCAN) begin
                // Strictly greater: on a tie the earlier index is kept.
                if (snap[idx] > best_val) begin
                    best_val <= snap[idx];
                    best_idx <= idx;
                end
                if (idx != LAST_IDX) begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_layer_argmax.sv
// tb/tb_layer_argmax.sv - directed self-checking bench for layer_argmax
module tb_layer_argmax;

    localparam int W = 24;
    localparam int N = 10;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] data_in [0:N-1];
    logic                out_valid;
    logic                out_ready;
    logic [3:0]          class_idx;
    logic signed [W-1:0] class_score;
    logic                busy;

    logic                in_valid1;
    logic                in_ready1;
    logic signed [W-1:0] data_in1 [0:0];
    logic                out_valid1;
    logic                out_ready1;
    logic [0:0]          class_idx1;
    logic signed [W-1:0] class_score1;
    logic                busy1;

    int vectors;
    int miscompares;

    layer_argmax #(.LAYER_DATA_WIDTH(16), .NEURON_NUM(N)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .class_idx(class_idx), .class_score(class_score), .busy(busy)
    );

    layer_argmax #(.LAYER_DATA_WIDTH(16), .NEURON_NUM(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .data_in(data_in1), .out_valid(out_valid1), .out_ready(out_ready1),
        .class_idx(class_idx1), .class_score(class_score1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts rising edges after the accept edge until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        vectors++;
        if (!out_valid) begin
            miscompares++;
            $display("FAIL wait_done: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
        end
    endtask

    task automatic start_and_wait(output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(lat);
    endtask

    task automatic handoff();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            class_idx !== 4'd0 || class_score !== 24'sd0) begin
            miscompares++;
            $display("FAIL reset_outputs: rdy=%0b ov=%0b busy=%0b idx=%0d score=%0d, required 0 0 0 0 0",
                     in_ready, out_valid, busy, class_idx, class_score);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: in_ready=%0b/%0b, required 1/1", in_ready, in_ready1);
        end
    endtask

    task automatic test_ascending();
        int lat;
        for (int i = 0; i < N; i++) data_in[i] = 24'(i);
        start_and_wait(lat);
        vectors++;
        if (lat != 9 || class_idx !== 4'd9 || class_score !== 24'sd9 || in_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ascending: lat=%0d idx=%0d score=%0d rdy=%0b busy=%0b, required 9 9 9 0 1",
                     lat, class_idx, class_score, in_ready, busy);
        end
        handoff();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ascending_handoff: ov=%0b rdy=%0b busy=%0b, required 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_ties();
        int lat;
        for (int i = 0; i < N; i++) data_in[i] = -24'sd5;
        start_and_wait(lat);
        vectors++;
        if (class_idx !== 4'd0 || class_score !== -24'sd5) begin
            miscompares++;
            $display("FAIL tie_all: idx=%0d score=%0d, required 0 -5", class_idx, class_score);
        end
        handoff();
        for (int i = 0; i < N; i++) data_in[i] = 24'sd0;
        data_in[3] = 24'sd100;
        data_in[7] = 24'sd100;
        start_and_wait(lat);
        vectors++;
        if (class_idx !== 4'd3 || class_score !== 24'sd100) begin
            miscompares++;
            $display("FAIL tie_pair: idx=%0d score=%0d, required 3 100", class_idx, class_score);
        end
        handoff();
    endtask

    task automatic test_negative();
        int lat;
        data_in[0] = -24'sd100; data_in[1] = -24'sd3;   data_in[2] = -24'sd50;
        data_in[3] = -24'sd60;  data_in[4] = -24'sd70;  data_in[5] = -24'sd80;
        data_in[6] = -24'sd90;  data_in[7] = -24'sd200; data_in[8] = -24'sd300;
        data_in[9] = 24'sh800000;
        start_and_wait(lat);
        vectors++;
        if (class_idx !== 4'd1 || class_score !== -24'sd3) begin
            miscompares++;
            $display("FAIL all_negative: idx=%0d score=%0d, required 1 -3", class_idx, class_score);
        end
        handoff();
        for (int i = 0; i < N; i++) data_in[i] = 24'sh800000;
        data_in[5] = 24'sh800001;
        start_and_wait(lat);
        vectors++;
        if (class_idx !== 4'd5 || class_score !== 24'sh800001) begin
            miscompares++;
            $display("FAIL most_negative: idx=%0d score=%0d, required 5 -8388607", class_idx, class_score);
        end
        handoff();
    endtask

    task automatic test_backpressure();
        int lat;
        for (int i = 0; i < N; i++) data_in[i] = 24'(i);
        data_in[4] = 24'sd77;
        start_and_wait(lat);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            for (int i = 0; i < N; i++) data_in[i] = 24'sd5000 + 24'(c);
            @(posedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b1 || class_idx !== 4'd4 || class_score !== 24'sd77 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure_hold: ov=%0b idx=%0d score=%0d rdy=%0b, required 1 4 77 0",
                         out_valid, class_idx, class_score, in_ready);
            end
        end
        for (int i = 0; i < N; i++) data_in[i] = 24'sd1;
        data_in[8] = 24'sd123;
        handoff();
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL no_same_cycle_accept: ov=%0b busy=%0b rdy=%0b, required 0 0 1", out_valid, busy, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL accept_after_handoff: busy=%0b rdy=%0b, required 1 0", busy, in_ready);
        end
        wait_done(lat);
        vectors++;
        if (lat != 9 || class_idx !== 4'd8 || class_score !== 24'sd123) begin
            miscompares++;
            $display("FAIL next_vector: lat=%0d idx=%0d score=%0d, required 9 8 123", lat, class_idx, class_score);
        end
        handoff();
    endtask

    task automatic test_snapshot();
        int lat;
        for (int i = 0; i < N; i++) data_in[i] = 24'sd10;
        data_in[2] = 24'sd50;
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 40 && !out_valid) begin
            for (int i = 0; i < N; i++) data_in[i] = 24'sd1000 * 24'(lat + 1) + 24'(i);
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (out_valid !== 1'b1 || lat != 9 || class_idx !== 4'd2 || class_score !== 24'sd50) begin
            miscompares++;
            $display("FAIL snapshot: ov=%0b lat=%0d idx=%0d score=%0d, required 1 9 2 50",
                     out_valid, lat, class_idx, class_score);
        end
        handoff();
    endtask

    task automatic test_back_to_back();
        int lat;
        for (int i = 0; i < N; i++) data_in[i] = 24'(N - i);
        out_ready = 1'b1;
        start_and_wait(lat);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_handoff: ov=%0b busy=%0b rdy=%0b, required 0 0 1", out_valid, busy, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || class_idx !== 4'd0 || class_score !== 24'sd10) begin
            miscompares++;
            $display("FAIL b2b_reaccept: busy=%0b rdy=%0b idx=%0d score=%0d, required 1 0 0 10",
                     busy, in_ready, class_idx, class_score);
        end
        out_ready = 1'b0;
        wait_done(lat);
        handoff();
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        for (int i = 0; i < N; i++) data_in[i] = 24'(i);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || class_idx !== 4'd0 || class_score !== 24'sd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_scan: ov=%0b idx=%0d score=%0d busy=%0b rdy=%0b, required 0 0 0 0 0",
                     out_valid, class_idx, class_score, busy, in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        start_and_wait(lat);
        vectors++;
        if (lat != 9 || class_idx !== 4'd9 || class_score !== 24'sd9) begin
            miscompares++;
            $display("FAIL after_reset: lat=%0d idx=%0d score=%0d, required 9 9 9", lat, class_idx, class_score);
        end
        handoff();
    endtask

    task automatic test_single();
        data_in1[0] = 24'sd42;
        @(negedge clk);
        in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        vectors++;
        if (out_valid1 !== 1'b1 || class_idx1 !== 1'b0 || class_score1 !== 24'sd42 || in_ready1 !== 1'b0) begin
            miscompares++;
            $display("FAIL single_neuron: ov=%0b idx=%0d score=%0d rdy=%0b, required 1 0 42 0",
                     out_valid1, class_idx1, class_score1, in_ready1);
        end
        @(negedge clk);
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        out_ready1 = 1'b0;
        vectors++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            miscompares++;
            $display("FAIL single_handoff: ov=%0b rdy=%0b, required 0 1", out_valid1, in_ready1);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_valid1   = 1'b0;
        out_ready1  = 1'b0;
        data_in1[0] = '0;
        for (int i = 0; i < N; i++) data_in[i] = '0;
        test_reset();
        test_ascending();
        test_ties();
        test_negative();
        test_backpressure();
        test_snapshot();
        test_back_to_back();
        test_reset_mid_scan();
        test_single();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
